// File: rtl/hit_judge_pkg.sv
// hit_judge_pkg -- shared definitions for the rhythm-game hit judge.
//   Judge codes, per-judgement score increments, the default arrow-lane
//   count and a saturating 16-bit adder used by the score accumulator.
//   No ports; imported by hit_judge and button_edge.
package hit_judge_pkg;

  // Lane count is NUM_ARROWS_BITS+1 (L,D,U,R for the default of 3).
  localparam int NUM_ARROWS_BITS_DFLT = 3;

  typedef enum logic [1:0] {
    JUDGE_NONE    = 2'd0,
    JUDGE_PERFECT = 2'd1,
    JUDGE_GOOD    = 2'd2,
    JUDGE_MISS    = 2'd3
  } judge_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REST   = 2'd1,
    ST_OPEN   = 2'd2,
    ST_CLOSED = 2'd3
  } state_e;

  localparam logic [15:0] SCORE_PERFECT = 16'd3;
  localparam logic [15:0] SCORE_GOOD    = 16'd1;
  localparam logic [15:0] SCORE_MISS    = 16'd0;

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

endpackage

// File: rtl/hit_judge_button_edge.sv
// button_edge -- registered rising-edge detector for the pad buttons.
//   clk        : system clock
//   rst        : synchronous active-high reset
//   buttons    : debounced level-high buttons, one bit per lane
//   press_edge : one-cycle pulse per lane, one cycle after the level rises
module button_edge
  import hit_judge_pkg::*;
#(
  parameter int WIDTH = NUM_ARROWS_BITS_DFLT + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] buttons,
  output logic [WIDTH-1:0] press_edge
);

  logic [WIDTH-1:0] buttons_q, buttons_d;
  logic [WIDTH-1:0] edge_q, edge_d;

  always_comb begin
    buttons_d = buttons;
    edge_d    = buttons & ~buttons_q;
  end

  // The edge itself is registered so the judge sees a clean pulse; this is
  // what puts a press rising in cycle t into the judgement visible at t+2.
  always_ff @(posedge clk) begin
    if (rst) begin
      buttons_q <= '0;
      edge_q    <= '0;
    end else begin
      buttons_q <= buttons_d;
      edge_q    <= edge_d;
    end
  end

  assign press_edge = edge_q;

endmodule

// File: rtl/hit_judge.sv
// hit_judge -- judges player presses against the arrow due on each beat.
//   clk          : system clock, all logic on posedge
//   rst          : synchronous active-high reset
//   beat         : one-cycle pulse when the arrow buffer shifts
//   target_arrow : lane mask that must be hit, sampled on beat (0 = rest)
//   buttons      : debounced level-high pad buttons
//   judge        : last judgement (NONE/PERFECT/GOOD/MISS), held
//   judge_valid  : one-cycle pulse when judge is updated
//   score        : saturating accumulated score
//   combo        : consecutive non-MISS judgements, saturating
//   max_combo    : highest combo since reset
//
// state  | meaning
// IDLE   | after reset, waiting for the first beat
// REST   | rest beat: any press is a MISS
// OPEN   | collecting presses for the target mask
// CLOSED | window judged, presses ignored until next beat
module hit_judge
  import hit_judge_pkg::*;
#(
  parameter int NUM_ARROWS_BITS = NUM_ARROWS_BITS_DFLT,
  parameter int PERFECT_CYCLES  = 5000000,
  parameter int GOOD_CYCLES     = 15000000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     beat,
  input  logic [NUM_ARROWS_BITS:0] target_arrow,
  input  logic [NUM_ARROWS_BITS:0] buttons,
  output logic [1:0]               judge,
  output logic                     judge_valid,
  output logic [15:0]              score,
  output logic [7:0]               combo,
  output logic [7:0]               max_combo
);

  localparam int W = NUM_ARROWS_BITS + 1;

  logic [W-1:0] press_edge;

  button_edge #(.WIDTH(W)) u_button_edge (
    .clk        (clk),
    .rst        (rst),
    .buttons    (buttons),
    .press_edge (press_edge)
  );

  state_e       state_q, state_d;
  logic [W-1:0] tgt_q, tgt_d;
  logic [W-1:0] acc_q, acc_d;
  logic [23:0]  elapsed_q, elapsed_d;
  judge_e       judge_q, judge_d;
  logic         judge_valid_q, judge_valid_d;
  logic [15:0]  score_q, score_d;
  logic [7:0]   combo_q, combo_d;
  logic [7:0]   max_combo_q, max_combo_d;

  judge_e       verdict;
  logic [W-1:0] acc_next;
  logic [31:0]  elapsed_ext;
  judge_e       timed_grade;

  always_comb begin
    elapsed_ext = {8'd0, elapsed_q};
    if (elapsed_ext < 32'(PERFECT_CYCLES)) begin
      timed_grade = JUDGE_PERFECT;
    end else if (elapsed_ext < 32'(GOOD_CYCLES)) begin
      timed_grade = JUDGE_GOOD;
    end else begin
      timed_grade = JUDGE_MISS;
    end
  end

  // Window FSM: decides at most one verdict per cycle.
  always_comb begin
    state_d   = state_q;
    tgt_d     = tgt_q;
    acc_d     = acc_q;
    elapsed_d = elapsed_q;
    verdict   = JUDGE_NONE;
    acc_next  = acc_q | press_edge;

    if (beat) begin
      // An unfinished window is closed out as a MISS on the beat that ends it.
      // Edges arriving on a beat cycle are dropped.
      if (state_q == ST_OPEN) verdict = JUDGE_MISS;
      tgt_d     = target_arrow;
      acc_d     = '0;
      elapsed_d = '0;
      state_d   = (target_arrow != '0) ? ST_OPEN : ST_REST;
    end else begin
      if (elapsed_q != '1) elapsed_d = elapsed_q + 24'd1;
      unique case (state_q)
        ST_REST: begin
          if (press_edge != '0) begin
            verdict = JUDGE_MISS;
            state_d = ST_CLOSED;
          end
        end
        ST_OPEN: begin
          acc_d = acc_next;
          if ((acc_next & ~tgt_q) != '0) begin
            verdict = JUDGE_MISS;
            state_d = ST_CLOSED;
          end else if (acc_next == tgt_q) begin
            verdict = timed_grade;
            state_d = ST_CLOSED;
          end
        end
        default: ;
      endcase
    end
  end

  // Score / combo bookkeeping for the verdict decided this cycle.
  always_comb begin
    judge_d       = judge_q;
    judge_valid_d = 1'b0;
    score_d       = score_q;
    combo_d       = combo_q;
    max_combo_d   = max_combo_q;

    if (verdict != JUDGE_NONE) begin
      judge_d       = verdict;
      judge_valid_d = 1'b1;
      unique case (verdict)
        JUDGE_PERFECT: begin
          score_d = sat_add16(score_q, SCORE_PERFECT);
          combo_d = (combo_q == 8'hFF) ? 8'hFF : combo_q + 8'd1;
        end
        JUDGE_GOOD: begin
          score_d = sat_add16(score_q, SCORE_GOOD);
          combo_d = (combo_q == 8'hFF) ? 8'hFF : combo_q + 8'd1;
        end
        default: begin
          score_d = sat_add16(score_q, SCORE_MISS);
          combo_d = 8'd0;
        end
      endcase
      if (combo_d > max_combo_q) max_combo_d = combo_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      tgt_q         <= '0;
      acc_q         <= '0;
      elapsed_q     <= '0;
      judge_q       <= JUDGE_NONE;
      judge_valid_q <= 1'b0;
      score_q       <= '0;
      combo_q       <= '0;
      max_combo_q   <= '0;
    end else begin
      state_q       <= state_d;
      tgt_q         <= tgt_d;
      acc_q         <= acc_d;
      elapsed_q     <= elapsed_d;
      judge_q       <= judge_d;
      judge_valid_q <= judge_valid_d;
      score_q       <= score_d;
      combo_q       <= combo_d;
      max_combo_q   <= max_combo_d;
    end
  end

  assign judge       = judge_q;
  assign judge_valid = judge_valid_q;
  assign score       = score_q;
  assign combo       = combo_q;
  assign max_combo   = max_combo_q;

endmodule

// File: tb/tb_hit_judge.sv
// tb_hit_judge -- randomized and directed bench for hit_judge with a
// cycle-level reference model of the judging rules.
module tb_hit_judge;

  localparam int P_CYC = 4;
  localparam int G_CYC = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic        beat;
  logic [3:0]  target_arrow;
  logic [3:0]  buttons;
  logic [1:0]  judge;
  logic        judge_valid;
  logic [15:0] score;
  logic [7:0]  combo;
  logic [7:0]  max_combo;

  hit_judge #(
    .NUM_ARROWS_BITS (3),
    .PERFECT_CYCLES  (P_CYC),
    .GOOD_CYCLES     (G_CYC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .beat         (beat),
    .target_arrow (target_arrow),
    .buttons      (buttons),
    .judge        (judge),
    .judge_valid  (judge_valid),
    .score        (score),
    .combo        (combo),
    .max_combo    (max_combo)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int n_valid = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Reference model: window kind (0 none, 1 rest, 2 open, 3 judged),
  // the needed and collected lane sets, and time since the beat.
  int m_kind, m_need, m_got, m_time, m_prev_btn, m_pend_edge;
  int m_score, m_combo, m_max, m_judge, m_valid;

  function automatic int grade(input int t);
    if (t < P_CYC) return 1;
    if (t < G_CYC) return 2;
    return 3;
  endfunction

  task automatic model_reset();
    m_kind = 0; m_need = 0; m_got = 0; m_time = 0; m_prev_btn = 0; m_pend_edge = 0;
    m_score = 0; m_combo = 0; m_max = 0; m_judge = 0; m_valid = 0;
  endtask

  task automatic model_step(input bit r, input bit b, input int t, input int btn);
    int v, e;
    if (r) begin
      model_reset();
      return;
    end
    v = 0;
    e = m_pend_edge;
    if (b) begin
      if (m_kind == 2) v = 3;
      m_need = t; m_got = 0; m_time = 0;
      m_kind = (t != 0) ? 2 : 1;
    end else begin
      if (m_kind == 1 && e != 0) begin
        v = 3; m_kind = 3;
      end else if (m_kind == 2) begin
        m_got = m_got | e;
        if ((m_got & ~m_need & 15) != 0) begin
          v = 3; m_kind = 3;
        end else if (m_got == m_need) begin
          v = grade(m_time); m_kind = 3;
        end
      end
      if (m_time < 24'hFFFFFF) m_time++;
    end
    m_valid = (v != 0);
    if (v != 0) begin
      m_judge = v;
      if (v == 3) m_combo = 0;
      else begin
        m_score = (m_score + ((v == 1) ? 3 : 1) > 65535) ? 65535 : m_score + ((v == 1) ? 3 : 1);
        m_combo = (m_combo < 255) ? m_combo + 1 : 255;
      end
      if (m_combo > m_max) m_max = m_combo;
    end
    m_pend_edge = btn & ~m_prev_btn & 15;
    m_prev_btn  = btn;
  endtask

  task automatic tick(input bit r, input bit b, input logic [3:0] t, input logic [3:0] btn);
    rst = r; beat = b; target_arrow = t; buttons = btn;
    @(posedge clk);
    model_step(r, b, int'(t), int'(btn));
    #1;
    if (judge_valid === 1'b1) n_valid++;
    chk("judge_valid", 32'(judge_valid), 32'(m_valid));
    chk("judge",       32'(judge),       32'(m_judge));
    chk("score",       32'(score),       32'(m_score));
    chk("combo",       32'(combo),       32'(m_combo));
    chk("max_combo",   32'(max_combo),   32'(m_max));
  endtask

  task automatic idle(input int n, input logic [3:0] btn);
    for (int i = 0; i < n; i++) tick(0, 0, 4'd0, btn);
  endtask

  task automatic do_reset();
    tick(1, 0, 4'd0, 4'd0);
    tick(0, 0, 4'd0, 4'd0);
    n_valid = 0;
  endtask

  task automatic perfect_win();
    tick(0, 1, 4'b0001, 4'b0000);
    tick(0, 0, 4'b0000, 4'b0001);
    tick(0, 0, 4'b0000, 4'b0000);
  endtask

  initial begin
    model_reset();
    rst = 1'b1; beat = 1'b0; target_arrow = '0; buttons = '0;
    tick(1, 0, 4'd0, 4'd0);
    chk("rst_score", 32'(score), 32'd0);
    chk("rst_judge", 32'(judge), 32'd0);

    // Single-lane hit three cycles after the beat: PERFECT.
    do_reset();
    tick(0, 1, 4'b0001, 4'b0000);
    idle(2, 4'b0000);
    idle(3, 4'b0001);
    chk("d31_judge", 32'(judge), 32'd1);
    chk("d31_score", 32'(score), 32'd3);
    chk("d31_combo", 32'(combo), 32'd1);

    // Two-lane target completed late: one GOOD only.
    do_reset();
    tick(0, 1, 4'b0110, 4'b0000);
    idle(1, 4'b0000);
    idle(4, 4'b0010);
    chk("d32_nojudge", 32'(n_valid), 32'd0);
    idle(4, 4'b0110);
    chk("d32_judge", 32'(judge), 32'd2);
    chk("d32_score", 32'(score), 32'd1);
    chk("d32_count", 32'(n_valid), 32'd1);

    // Wrong lane: MISS, then later presses ignored.
    do_reset();
    tick(0, 1, 4'b0001, 4'b0000);
    idle(1, 4'b0000);
    idle(3, 4'b0010);
    chk("d33_judge", 32'(judge), 32'd3);
    chk("d33_combo", 32'(combo), 32'd0);
    n_valid = 0;
    idle(2, 4'b0000);
    idle(3, 4'b0001);
    chk("d33_quiet", 32'(n_valid), 32'd0);

    // Unhit window closed by the next beat, new window still works.
    do_reset();
    perfect_win();
    tick(0, 1, 4'b1000, 4'b0000);
    idle(5, 4'b0000);
    n_valid = 0;
    tick(0, 1, 4'b0001, 4'b0000);
    chk("d34_valid", 32'(judge_valid), 32'd1);
    chk("d34_judge", 32'(judge), 32'd3);
    chk("d34_score", 32'(score), 32'd3);
    chk("d34_combo", 32'(combo), 32'd0);
    idle(1, 4'b0001);
    idle(2, 4'b0000);
    chk("d34_reopen", 32'(judge), 32'd1);

    // Reset mid-window with a press in the same cycle.
    do_reset();
    perfect_win();
    tick(0, 1, 4'b0001, 4'b0000);
    n_valid = 0;
    tick(1, 1, 4'b0010, 4'b0001);
    chk("d36_score", 32'(score), 32'd0);
    chk("d36_combo", 32'(combo), 32'd0);
    chk("d36_max",   32'(max_combo), 32'd0);
    chk("d36_judge", 32'(judge), 32'd0);
    idle(4, 4'b0001);
    chk("d36_quiet", 32'(n_valid), 32'd0);

    // Random traffic against the model.
    do_reset();
    begin
      logic [3:0] btn, tg;
      btn = '0;
      for (int i = 0; i < 4000; i++) begin
        tg = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 3) == 0) tg = '0;
        if ($urandom_range(0, 2) == 0) btn = 4'($urandom_range(0, 15));
        tick($urandom_range(0, 299) == 0, $urandom_range(0, 5) == 0, tg, btn);
      end
    end

    // Combo saturation, MISS, then score saturation.
    do_reset();
    for (int i = 0; i < 300; i++) perfect_win();
    chk("d35_combo", 32'(combo), 32'hFF);
    chk("d35_max",   32'(max_combo), 32'hFF);
    chk("d35_score", 32'(score), 32'd900);
    tick(0, 1, 4'b0001, 4'b0000);
    idle(1, 4'b0010);
    idle(1, 4'b0000);
    chk("d35_miss_combo", 32'(combo), 32'd0);
    chk("d35_miss_max",   32'(max_combo), 32'hFF);
    for (int i = 0; i < 21600; i++) perfect_win();
    chk("d35_score_sat", 32'(score), 32'hFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
